// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and PC-source encodings for the fetch sequencer
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - combinational next-PC selection (PC+4, PC+ImmExt, JALR target)
module pc_next_logic
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] PC,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] ALUResult,
    output logic [XLEN-1:0] PCPlus4,
    output logic [XLEN-1:0] PCNext
);

    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_target;

    // Both adders wrap modulo 2^XLEN; there is deliberately no carry-out.
    assign PCPlus4       = PC + XLEN'(4);
    assign branch_target = PC + ImmExt;
    assign jalr_target   = {ALUResult[XLEN-1:1], 1'b0};

    always_comb begin
        PCNext = PCPlus4;
        case (PCSrc)
            PCSRC_BRANCH: PCNext = branch_target;
            PCSRC_JALR:   PCNext = jalr_target;
            default:      PCNext = PCPlus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and req/ack fetch sequencer; optional MISALIGN_TRAP_EN
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
`ifdef MISALIGN_TRAP_EN
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
`endif
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] ALUResult,
    output logic            InstrReq,
    output logic [XLEN-1:0] InstrAddr,
    input  logic            InstrAck,
    input  logic [31:0]     InstrRdata,
    output logic            InstrValid,
    input  logic            InstrReady,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            MisalignTrap
);

    fetch_state_t    state, state_next;
    logic            pc_load;
    logic            instr_load;
    logic [XLEN-1:0] pc_next;

    pc_next_logic #(.XLEN(XLEN)) u_next (
        .PC        (PC),
        .PCSrc     (PCSrc),
        .ImmExt    (ImmExt),
        .ALUResult (ALUResult),
        .PCPlus4   (PCPlus4),
        .PCNext    (pc_next)
    );

    assign InstrAddr = PC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_next;
    end

    // Handshake outputs decode straight from state so reset drops InstrReq immediately.
    always_comb begin
        state_next = state;
        InstrReq   = 1'b0;
        InstrValid = 1'b0;
        pc_load    = 1'b0;
        instr_load = 1'b0;
        case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                InstrReq = 1'b1;
                if (InstrAck) begin
                    instr_load = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                InstrValid = 1'b1;
                if (InstrReady) begin
                    pc_load    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           Instr <= 32'h0;
        else if (instr_load) Instr <= InstrRdata;
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC           <= RESET_VECTOR;
            MisalignTrap <= 1'b0;
        end else begin
            MisalignTrap <= 1'b0;
            if (pc_load) begin
                if (|pc_next[1:0]) begin
                    PC           <= TRAP_VECTOR;
                    MisalignTrap <= 1'b1;
                end else begin
                    PC <= pc_next;
                end
            end
        end
    end
`else
    // Without the trap, low address bits are simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        PC <= RESET_VECTOR;
        else if (pc_load) PC <= pc_next & ~XLEN'(3);
    end

    assign MisalignTrap = 1'b0;
`endif

endmodule
